// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port among N_REQ requesters.
// Responses are routed back in order through a FIFO of granted requester IDs.
module fc_l2_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            s_req_i,
  input  logic [N_REQ*ADDR_W-1:0]     s_add_i,
  input  logic [N_REQ-1:0]            s_wen_i,
  input  logic [N_REQ*DATA_W-1:0]     s_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0]   s_be_i,
  output logic [N_REQ-1:0]            s_gnt_o,
  output logic [N_REQ-1:0]            s_r_valid_o,
  output logic [DATA_W-1:0]           s_r_rdata_o,
  output logic                        s_r_opc_o,
  output logic                        m_req_o,
  output logic [ADDR_W-1:0]           m_add_o,
  output logic                        m_wen_o,
  output logic [DATA_W-1:0]           m_wdata_o,
  output logic [DATA_W/8-1:0]         m_be_o,
  input  logic                        m_gnt_i,
  input  logic                        m_r_valid_i,
  input  logic [DATA_W-1:0]           m_r_rdata_i,
  input  logic                        m_r_opc_i,
  output logic                        orphan_o,
  output logic [$clog2(MAX_OUTST):0]  outst_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             orphan_q, orphan_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTST];
  logic [ID_W-1:0]  fifo_d [MAX_OUTST];

  logic [ID_W:0]    cand_sum;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  head;
  logic             any_req;
  logic             full;
  logic             hs;
  logic             pop;

  // Rotating priority search starting at the RR pointer, wrapping at N_REQ.
  always_comb begin
    win      = '0;
    any_req  = 1'b0;
    cand_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(N_REQ)) cand_sum = cand_sum - (ID_W+1)'(N_REQ);
      if (!any_req && s_req_i[cand_sum[ID_W-1:0]]) begin
        win     = cand_sum[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // req/gnt: a transfer is accepted in the cycle where m_req_o and m_gnt_i are
  // both high; the winning requester holds its fields until it sees s_gnt_o.
  always_comb begin
    full        = (cnt_q == MAX_CNT);
    m_req_o     = any_req & ~full;
    hs          = m_req_o & m_gnt_i;
    pop         = m_r_valid_i & (cnt_q != '0);
    head        = fifo_q[rd_ptr_q];
    m_add_o     = '0;
    m_wen_o     = 1'b0;
    m_wdata_o   = '0;
    m_be_o      = '0;
    s_gnt_o     = '0;
    s_r_valid_o = '0;
    if (m_req_o) begin
      m_add_o   = s_add_i[win*ADDR_W +: ADDR_W];
      m_wen_o   = s_wen_i[win];
      m_wdata_o = s_wdata_i[win*DATA_W +: DATA_W];
      m_be_o    = s_be_i[win*BE_W +: BE_W];
    end
    if (hs)  s_gnt_o[win]      = 1'b1;
    if (pop) s_r_valid_o[head] = 1'b1;
    s_r_rdata_o = m_r_rdata_i;
    s_r_opc_o   = m_r_opc_i;
    orphan_o    = orphan_q;
    outst_o     = cnt_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    orphan_d = orphan_q | (m_r_valid_i & (cnt_q == '0));
    fifo_d   = fifo_q;
    if (hs) begin
      rr_ptr_d         = (win == LAST_ID) ? '0 : win + 1'b1;
      fifo_d[wr_ptr_q] = win;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Push is blocked at full, so push+pop never overflows the count.
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Directed vector bench for fc_l2_port_arbiter: per-cycle stimulus with
// hand-computed grants, responses, outstanding count and orphan flag.
module tb_fc_l2_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk;
  logic              rst_i;
  logic [N-1:0]      s_req_i;
  logic [N*AW-1:0]   s_add_i;
  logic [N-1:0]      s_wen_i;
  logic [N*DW-1:0]   s_wdata_i;
  logic [N*BW-1:0]   s_be_i;
  logic [N-1:0]      s_gnt_o;
  logic [N-1:0]      s_r_valid_o;
  logic [DW-1:0]     s_r_rdata_o;
  logic              s_r_opc_o;
  logic              m_req_o;
  logic [AW-1:0]     m_add_o;
  logic              m_wen_o;
  logic [DW-1:0]     m_wdata_o;
  logic [BW-1:0]     m_be_o;
  logic              m_gnt_i;
  logic              m_r_valid_i;
  logic [DW-1:0]     m_r_rdata_i;
  logic              m_r_opc_i;
  logic              orphan_o;
  logic [2:0]        outst_o;

  fc_l2_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
    .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
    .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
    .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_gnt_i(m_gnt_i),
    .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i), .m_r_opc_i(m_r_opc_i),
    .orphan_o(orphan_o), .outst_o(outst_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    logic [3:0] req;
    bit        gnt;
    bit        rv;
    logic [3:0] exp_gnt;
    logic [3:0] exp_rv;
    bit        exp_mreq;
    logic [2:0] exp_outst;
    bit        exp_orphan;
    int        exp_win;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         step   = 0;

  function automatic vec_t v(bit rst, logic [3:0] req, bit gnt, bit rv,
                             logic [3:0] eg, logic [3:0] erv, bit emreq,
                             logic [2:0] eout, bit eorph, int ewin);
    vec_t r;
    r.rst = rst; r.req = req; r.gnt = gnt; r.rv = rv;
    r.exp_gnt = eg; r.exp_rv = erv; r.exp_mreq = emreq;
    r.exp_outst = eout; r.exp_orphan = eorph; r.exp_win = ewin;
    return r;
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction
  function automatic logic [DW-1:0] wdata_of(int i);
    return 32'h1111_1111 * 32'(i + 1);
  endfunction
  function automatic logic [BW-1:0] be_of(int i);
    return 4'b0001 << i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // driver + checker for one cycle
  task automatic apply(input vec_t t);
    logic [1:0] id;
    @(posedge clk); #1;
    rst_i       = t.rst;
    s_req_i     = t.req;
    m_gnt_i     = t.gnt;
    m_r_valid_i = t.rv;
    m_r_rdata_i = $urandom;
    m_r_opc_i   = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("gnt",    64'(s_gnt_o),     64'(t.exp_gnt));
    chk("rvalid", 64'(s_r_valid_o), 64'(t.exp_rv));
    chk("mreq",   64'(m_req_o),     64'(t.exp_mreq));
    chk("outst",  64'(outst_o),     64'(t.exp_outst));
    chk("orphan", 64'(orphan_o),    64'(t.exp_orphan));
    chk("rdata",  64'(s_r_rdata_o), 64'(m_r_rdata_i));
    chk("opc",    64'(s_r_opc_o),   64'(m_r_opc_i));
    if (t.exp_win >= 0) begin
      chk("add",   64'(m_add_o),   64'(addr_of(t.exp_win)));
      chk("wen",   64'(m_wen_o),   64'(t.exp_win % 2));
      chk("wdata", 64'(m_wdata_o), 64'(wdata_of(t.exp_win)));
      chk("be",    64'(m_be_o),    64'(be_of(t.exp_win)));
    end else begin
      chk("add_idle", 64'(m_add_o), 64'd0);
      chk("be_idle",  64'(m_be_o),  64'd0);
    end
    // scoreboard: in-order response routing against granted IDs
    if (s_r_valid_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 64'(s_r_valid_o), 64'd0);
      end else begin
        id = exp_q.pop_front();
        chk("sb_route", 64'(s_r_valid_o), 64'(4'b0001 << id));
      end
    end
    if (t.exp_gnt != '0 && t.exp_win >= 0) exp_q.push_back(2'(t.exp_win));
    if (t.rst) exp_q.delete();
    step++;
  endtask

  initial begin
    rst_i = 1'b1; s_req_i = '0; m_gnt_i = 1'b0; m_r_valid_i = 1'b0;
    m_r_rdata_i = '0; m_r_opc_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_add_i[i*AW +: AW]   = addr_of(i);
      s_wen_i[i]            = 1'(i % 2);
      s_wdata_i[i*DW +: DW] = wdata_of(i);
      s_be_i[i*BW +: BW]    = be_of(i);
    end
    repeat (2) @(posedge clk);

    // all requesting, 1-cycle responder: rotation 0,1,2,3,0
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'hF, 1, 1, 4'h2, 4'h1, 1, 1, 0, 1));
    tbl.push_back(v(0, 4'hF, 1, 1, 4'h4, 4'h2, 1, 1, 0, 2));
    tbl.push_back(v(0, 4'hF, 1, 1, 4'h8, 4'h4, 1, 1, 0, 3));
    tbl.push_back(v(0, 4'hF, 1, 1, 4'h1, 4'h8, 1, 1, 0, 0));
    tbl.push_back(v(0, 4'h0, 1, 1, 4'h0, 4'h1, 0, 1, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    // req0 held without grant for 3 cycles, then granted; pointer moves to 1
    tbl.push_back(v(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    tbl.push_back(v(0, 4'h1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'h1, 1, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    tbl.push_back(v(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 1, 0, 1));
    tbl.push_back(v(0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 1, 0, -1));
    // fill to MAX_OUTST, stall, pop+request same cycle, refill, drain
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 0, 0, 1));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h4, 4'h0, 1, 1, 0, 2));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h8, 4'h0, 1, 2, 0, 3));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 3, 0, 0));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h0, 4'h0, 0, 4, 0, -1));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h0, 4'h0, 0, 4, 0, -1));
    tbl.push_back(v(0, 4'hF, 1, 1, 4'h0, 4'h2, 0, 4, 0, -1));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 3, 0, 1));
    tbl.push_back(v(0, 4'hF, 1, 0, 4'h0, 4'h0, 0, 4, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 1, 4'h0, 4'h4, 0, 4, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 1, 4'h0, 4'h8, 0, 3, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 2, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 1, 4'h0, 4'h2, 0, 1, 0, -1));
    tbl.push_back(v(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    foreach (tbl[i]) apply(tbl[i]);

    // response with nothing outstanding: not routed, orphan sticks
    apply(v(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    apply(v(0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    apply(v(0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 1, -1));
    apply(v(0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 0, 1, 0));
    apply(v(0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 1, 1, -1));

    // reset with 2 in flight: late responses are orphans, RR restarts at 0
    apply(v(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 1, -1));
    apply(v(0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    apply(v(0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 1, 0, 1));
    apply(v(1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2, 0, -1));
    apply(v(0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    apply(v(0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 1, -1));
    apply(v(0, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0, 1, 0));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
